// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// Reads resolve combinationally through state, commit bypass or ROB forward; commits and renames update on the clock.
module reg_file_rename #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             jump_wrong_flag,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_rename_flag,
  input  logic [4:0]       ID_rename_rd,
  input  logic [TAG_W-1:0] ID_rename_rob_id,
  output logic             RF_rs1_ready,
  output logic [31:0]      RF_rs1_val,
  output logic [TAG_W-1:0] RF_rs1_rob_id,
  output logic             RF_rs2_ready,
  output logic [31:0]      RF_rs2_val,
  output logic [TAG_W-1:0] RF_rs2_rob_id,
  output logic [TAG_W-1:0] RF_id1,
  output logic [TAG_W-1:0] RF_id2,
  input  logic             RF_id1_ready,
  input  logic             RF_id2_ready,
  input  logic [31:0]      RF_id1_val,
  input  logic [31:0]      RF_id2_val,
  input  logic             ROB_cmt_rf_flag,
  input  logic [4:0]       ROB_cmt_rf_rd,
  input  logic [TAG_W-1:0] ROB_cmt_rf_rob_id,
  input  logic [31:0]      ROB_cmt_rf_val
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RD_W = 1 + XLEN + TAG_W;

  logic [XLEN-1:0]  r_regs [NREG];
  logic [TAG_W-1:0] r_tag  [NREG];
  logic [NREG-1:0]  r_busy;

  logic w_cmt_en;
  logic w_ren_en;

  assign w_cmt_en = rdy && ROB_cmt_rf_flag && (ROB_cmt_rf_rd != 5'd0);
  assign w_ren_en = rdy && !jump_wrong_flag && ID_rename_flag && (ID_rename_rd != 5'd0);

  // Source resolution: {ready, value, producer tag}
  function automatic logic [RD_W-1:0] read_src(input logic [4:0] rs,
                                                input logic id_rdy,
                                                input logic [XLEN-1:0] id_val);
    logic            f_rdy;
    logic [XLEN-1:0] f_val;
    f_rdy = 1'b0;
    f_val = '0;
    if (rs == 5'd0) begin
      f_rdy = 1'b1;
    end else if (!r_busy[rs]) begin
      f_rdy = 1'b1;
      f_val = r_regs[rs];
    end else if (ROB_cmt_rf_flag && (ROB_cmt_rf_rd == rs) && (ROB_cmt_rf_rob_id == r_tag[rs])) begin
      f_rdy = 1'b1;
      f_val = ROB_cmt_rf_val;
    end else if (id_rdy) begin
      f_rdy = 1'b1;
      f_val = id_val;
    end
    return {f_rdy, f_val, r_tag[rs]};
  endfunction

  always_comb begin
    {RF_rs1_ready, RF_rs1_val, RF_rs1_rob_id} = read_src(ID_rs1, RF_id1_ready, RF_id1_val);
    {RF_rs2_ready, RF_rs2_val, RF_rs2_rob_id} = read_src(ID_rs2, RF_id2_ready, RF_id2_val);
  end

  assign RF_id1 = r_busy[ID_rs1] ? r_tag[ID_rs1] : '0;
  assign RF_id2 = r_busy[ID_rs2] ? r_tag[ID_rs2] : '0;

  // Later assignments win: flush clears everything, otherwise a rename overrides a commit's busy clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_tag[i]  <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_cmt_en) begin
        r_regs[ROB_cmt_rf_rd] <= ROB_cmt_rf_val;
        if (r_tag[ROB_cmt_rf_rd] == ROB_cmt_rf_rob_id) begin
          r_busy[ROB_cmt_rf_rd] <= 1'b0;
        end
      end
      if (rdy && jump_wrong_flag) begin
        r_busy <= '0;
      end else if (w_ren_en) begin
        r_busy[ID_rename_rd] <= 1'b1;
        r_tag[ID_rename_rd]  <= ID_rename_rob_id;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_rename.sv
// Bench for reg_file_rename: directed vector table, then random traffic against a reference model.
module tb_reg_file_rename;

  logic        clk, rst, rdy, flush;
  logic [4:0]  rs1, rs2, ren_rd, cmt_rd;
  logic        ren, cmt, id1_rdy, id2_rdy;
  logic [31:0] ren_id, cmt_id, cmt_val, id1_val, id2_val;
  logic        o1_rdy, o2_rdy;
  logic [31:0] o1_val, o2_val, o1_rob, o2_rob, o_id1, o_id2;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_tag  [32];
  bit          m_busy [32];

  reg_file_rename dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong_flag(flush),
    .ID_rs1(rs1), .ID_rs2(rs2),
    .ID_rename_flag(ren), .ID_rename_rd(ren_rd), .ID_rename_rob_id(ren_id),
    .RF_rs1_ready(o1_rdy), .RF_rs1_val(o1_val), .RF_rs1_rob_id(o1_rob),
    .RF_rs2_ready(o2_rdy), .RF_rs2_val(o2_val), .RF_rs2_rob_id(o2_rob),
    .RF_id1(o_id1), .RF_id2(o_id2),
    .RF_id1_ready(id1_rdy), .RF_id2_ready(id2_rdy),
    .RF_id1_val(id1_val), .RF_id2_val(id2_val),
    .ROB_cmt_rf_flag(cmt), .ROB_cmt_rf_rd(cmt_rd),
    .ROB_cmt_rf_rob_id(cmt_id), .ROB_cmt_rf_val(cmt_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, flush, ren;
    logic [4:0]  ren_rd;
    logic [31:0] ren_id;
    logic        cmt;
    logic [4:0]  cmt_rd;
    logic [31:0] cmt_id, cmt_val;
    logic [4:0]  rs1, rs2;
    logic        id1_rdy;
    logic [31:0] id1_val;
    logic        e1_rdy;
    logic [31:0] e1_val, e1_rob, e_id1;
    logic        e2_rdy;
    logic [31:0] e2_val;
  } vec_t;

  function automatic vec_t V(input int unsigned a_rst, a_rdy, a_fl, a_ren, a_rrd, a_rid,
                             a_cmt, a_crd, a_cid, a_cval, a_rs1, a_rs2, a_i1r, a_i1v,
                             a_e1r, a_e1v, a_e1rob, a_eid1, a_e2r, a_e2v);
    vec_t v;
    v.rst = 1'(a_rst); v.rdy = 1'(a_rdy); v.flush = 1'(a_fl); v.ren = 1'(a_ren);
    v.ren_rd = 5'(a_rrd); v.ren_id = a_rid;
    v.cmt = 1'(a_cmt); v.cmt_rd = 5'(a_crd); v.cmt_id = a_cid; v.cmt_val = a_cval;
    v.rs1 = 5'(a_rs1); v.rs2 = 5'(a_rs2); v.id1_rdy = 1'(a_i1r); v.id1_val = a_i1v;
    v.e1_rdy = 1'(a_e1r); v.e1_val = a_e1v; v.e1_rob = a_e1rob; v.e_id1 = a_eid1;
    v.e2_rdy = 1'(a_e2r); v.e2_val = a_e2v;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: expected read of one source from architectural state
  function automatic logic [64:0] m_read(input logic [4:0] rs, input logic ir, input logic [31:0] iv);
    if (rs == 5'd0) return {1'b1, 32'd0, 32'd0};
    if (!m_busy[rs]) return {1'b1, m_regs[rs], m_tag[rs]};
    if (cmt && cmt_rd == rs && cmt_id == m_tag[rs]) return {1'b1, cmt_val, m_tag[rs]};
    if (ir) return {1'b1, iv, m_tag[rs]};
    return {1'b0, 32'd0, m_tag[rs]};
  endfunction

  // Reference model: state after a clock edge given the inputs held during it
  task automatic model_step();
    bit renamed;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0; m_tag[i] = '0; m_busy[i] = 0;
      end
      return;
    end
    if (!rdy) return;
    renamed = ren && !flush && ren_rd != 5'd0;
    if (cmt && cmt_rd != 5'd0) begin
      m_regs[cmt_rd] = cmt_val;
      if (m_tag[cmt_rd] == cmt_id) m_busy[cmt_rd] = 0;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end
    if (renamed) begin
      m_busy[ren_rd] = 1;
      m_tag[ren_rd] = ren_id;
    end
  endtask

  task automatic check_model(input int n);
    logic [64:0] e1, e2;
    e1 = m_read(rs1, id1_rdy, id1_val);
    e2 = m_read(rs2, id2_rdy, id2_val);
    chk($sformatf("rnd%0d rs1_ready", n), 32'(o1_rdy), 32'(e1[64]));
    chk($sformatf("rnd%0d rs1_val", n), o1_val, e1[63:32]);
    if (!e1[64]) chk($sformatf("rnd%0d rs1_rob_id", n), o1_rob, e1[31:0]);
    chk($sformatf("rnd%0d rs2_ready", n), 32'(o2_rdy), 32'(e2[64]));
    chk($sformatf("rnd%0d rs2_val", n), o2_val, e2[63:32]);
    if (!e2[64]) chk($sformatf("rnd%0d rs2_rob_id", n), o2_rob, e2[31:0]);
    chk($sformatf("rnd%0d RF_id1", n), o_id1, m_busy[rs1] ? m_tag[rs1] : 32'd0);
    chk($sformatf("rnd%0d RF_id2", n), o_id2, m_busy[rs2] ? m_tag[rs2] : 32'd0);
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  vec_t tbl[$];

  initial begin
    // rst rdy fl | ren rd id | cmt rd id val | rs1 rs2 | i1r i1v | e1r e1v e1rob eid1 | e2r e2v
    tbl.push_back(V(0,1,0, 0,0,0, 0,0,0,0,       5,0, 0,0,       1,0,0,0,          1,0));
    tbl.push_back(V(0,1,0, 1,5,3, 0,0,0,0,       5,0, 0,0,       1,0,0,0,          1,0));
    tbl.push_back(V(0,1,0, 0,0,0, 0,0,0,0,       5,0, 0,0,       0,0,3,3,          1,0));
    tbl.push_back(V(0,1,0, 0,0,0, 0,0,0,0,       5,0, 1,'hAB,    1,'hAB,3,3,       1,0));
    tbl.push_back(V(0,1,0, 0,0,0, 1,5,3,'h1234,  5,0, 0,0,       1,'h1234,3,3,     1,0));
    tbl.push_back(V(0,1,0, 0,0,0, 0,0,0,0,       5,5, 1,'hDEAD,  1,'h1234,0,0,     1,'h1234));
    tbl.push_back(V(0,1,0, 1,5,3, 0,0,0,0,       5,0, 0,0,       1,'h1234,0,0,     1,0));
    tbl.push_back(V(0,1,0, 1,5,7, 0,0,0,0,       5,0, 0,0,       0,0,3,3,          1,0));
    tbl.push_back(V(0,1,0, 0,0,0, 1,5,3,'h11,    5,0, 0,0,       0,0,7,7,          1,0));
    tbl.push_back(V(0,1,1, 0,0,0, 0,0,0,0,       5,0, 0,0,       0,0,7,7,          1,0));
    tbl.push_back(V(0,1,0, 0,0,0, 0,0,0,0,       5,0, 0,0,       1,'h11,0,0,       1,0));
    tbl.push_back(V(0,1,0, 1,6,4, 0,0,0,0,       6,0, 0,0,       1,0,0,0,          1,0));
    tbl.push_back(V(0,1,0, 1,6,9, 1,6,4,'h55,    6,0, 0,0,       1,'h55,4,4,       1,0));
    tbl.push_back(V(0,1,0, 0,0,0, 0,0,0,0,       6,6, 0,0,       0,0,9,9,          0,0));
    tbl.push_back(V(0,1,1, 0,0,0, 0,0,0,0,       6,0, 0,0,       0,0,9,9,          1,0));
    tbl.push_back(V(0,1,0, 0,0,0, 0,0,0,0,       6,0, 0,0,       1,'h55,0,0,       1,0));
    tbl.push_back(V(0,1,0, 1,1,1, 0,0,0,0,       1,0, 0,0,       1,0,0,0,          1,0));
    tbl.push_back(V(0,1,0, 1,2,2, 0,0,0,0,       1,0, 0,0,       0,0,1,1,          1,0));
    tbl.push_back(V(0,1,0, 1,3,3, 0,0,0,0,       2,1, 0,0,       0,0,2,2,          0,0));
    tbl.push_back(V(0,1,1, 1,4,4, 1,1,1,'h80,    3,1, 0,0,       0,0,3,3,          1,'h80));
    tbl.push_back(V(0,1,0, 0,0,0, 0,0,0,0,       4,1, 0,0,       1,0,0,0,          1,'h80));
    tbl.push_back(V(0,1,0, 0,0,0, 0,0,0,0,       3,2, 0,0,       1,0,0,0,          1,0));
    tbl.push_back(V(0,1,0, 1,0,5, 1,0,5,'h99,    0,0, 0,0,       1,0,0,0,          1,0));
    tbl.push_back(V(0,1,0, 0,0,0, 0,0,0,0,       0,0, 1,'h77,    1,0,0,0,          1,0));
    tbl.push_back(V(0,0,0, 1,7,8, 1,5,0,'hEE,    7,5, 0,0,       1,0,0,0,          1,'h11));
    tbl.push_back(V(0,1,0, 0,0,0, 0,0,0,0,       7,5, 0,0,       1,0,0,0,          1,'h11));
    tbl.push_back(V(0,1,0, 1,8,2, 0,0,0,0,       8,0, 0,0,       1,0,0,0,          1,0));
    tbl.push_back(V(1,1,0, 0,0,0, 0,0,0,0,       8,5, 0,0,       0,0,2,2,          1,'h11));
    tbl.push_back(V(0,1,0, 0,0,0, 0,0,0,0,       8,5, 0,0,       1,0,0,0,          1,0));

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; ren = 1'b0; ren_rd = '0; ren_id = '0;
    cmt = 1'b0; cmt_rd = '0; cmt_id = '0; cmt_val = '0; rs1 = '0; rs2 = '0;
    id1_rdy = 1'b0; id1_val = '0; id2_rdy = 1'b0; id2_val = '0;
    @(negedge clk);
    clock_edge();
    clock_edge();

    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst; rdy = tbl[k].rdy; flush = tbl[k].flush;
      ren = tbl[k].ren; ren_rd = tbl[k].ren_rd; ren_id = tbl[k].ren_id;
      cmt = tbl[k].cmt; cmt_rd = tbl[k].cmt_rd; cmt_id = tbl[k].cmt_id; cmt_val = tbl[k].cmt_val;
      rs1 = tbl[k].rs1; rs2 = tbl[k].rs2; id1_rdy = tbl[k].id1_rdy; id1_val = tbl[k].id1_val;
      id2_rdy = 1'b0; id2_val = '0;
      #1;
      chk($sformatf("vec%0d rs1_ready", k), 32'(o1_rdy), 32'(tbl[k].e1_rdy));
      chk($sformatf("vec%0d rs1_val", k), o1_val, tbl[k].e1_val);
      if (!tbl[k].e1_rdy) chk($sformatf("vec%0d rs1_rob_id", k), o1_rob, tbl[k].e1_rob);
      chk($sformatf("vec%0d RF_id1", k), o_id1, tbl[k].e_id1);
      chk($sformatf("vec%0d rs2_ready", k), 32'(o2_rdy), 32'(tbl[k].e2_rdy));
      chk($sformatf("vec%0d rs2_val", k), o2_val, tbl[k].e2_val);
      clock_edge();
    end

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 15) == 0);
      ren = 1'($urandom);
      ren_rd = 5'($urandom_range(0, 7));
      ren_id = $urandom_range(0, 7);
      cmt = 1'($urandom);
      cmt_rd = 5'($urandom_range(0, 7));
      cmt_id = ($urandom_range(0, 1) == 1) ? m_tag[cmt_rd] : $urandom_range(0, 7);
      cmt_val = $urandom;
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      id1_rdy = 1'($urandom); id1_val = $urandom;
      id2_rdy = 1'($urandom); id2_val = $urandom;
      #1;
      check_model(n);
      clock_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
